// File: rtl/relu_requant_fifo.sv
// relu_requant_fifo
//   Takes the pooler's signed 32-bit result stream and applies ReLU, a fixed
//   arithmetic right shift and saturation to 16 bits. Results go into a
//   synchronous FIFO. The next layer pulls 16-bit activations with rd_en.
//   frame_done pulses once the FIFO has drained after the pooler's end-of-frame
//   level rises.
// Ports
//   clk, global_rst           clock; async active-high reset
//   in_data/in_valid/in_end   pooled result stream and end-of-frame level
//   rd_en                     read request from the next layer
//   out_data/out_valid        activation, valid one cycle after an accepted rd_en
//   full/empty/count          occupancy, decoded from the registered count
//   overflow                  sticky: a write was dropped because the FIFO was full
//   frame_done                one-cycle pulse: frame ended and FIFO drained
module relu_requant_fifo #(
    parameter int SHIFT = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    input  logic          in_end,
    input  logic          rd_en,
    output logic [15:0]   out_data,
    output logic          out_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          frame_done
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   out_data_q;
    logic          out_valid_q, overflow_q, frame_done_q, frame_done_d;
    logic          end_pending_q, end_pending_d, in_end_q;

    // Requantize. Negative inputs clamp to 0. A shifted value needing more
    // than 15 magnitude bits saturates to the largest positive int16.
    logic [31:0] shifted;
    logic [15:0] wr_val;
    always_comb begin
        shifted = in_data >> SHIFT;
        if (in_data[31])
            wr_val = 16'h0000;
        else if (|shifted[31:15])
            wr_val = 16'h7FFF;
        else
            wr_val = shifted[15:0];
    end

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A write while full is rejected even if a read is accepted this cycle.
    // A read while empty is ignored, so there is no read-through.
    logic wr_acc, rd_acc, end_rise;
    assign wr_acc   = in_valid && !full;
    assign rd_acc   = rd_en && !empty;
    assign end_rise = in_end && !in_end_q;

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // The drain check uses the registered count. A write accepted this cycle
    // means the frame is not drained yet. A second rise while pending is
    // absorbed because the pending flag is already set.
    always_comb begin
        frame_done_d  = end_pending_q && empty && !wr_acc;
        end_pending_d = end_pending_q;
        if (frame_done_d)
            end_pending_d = 1'b0;
        else if (end_rise)
            end_pending_d = 1'b1;
    end

    // The storage array has no reset. Its contents are unreachable until written.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= wr_val;
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            end_pending_q <= 1'b0;
            in_end_q      <= 1'b0;
        end else begin
            count_q       <= count_d;
            out_valid_q   <= rd_acc;
            frame_done_q  <= frame_done_d;
            end_pending_q <= end_pending_d;
            in_end_q      <= in_end;
            if (wr_acc)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) begin
                out_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q   <= rd_ptr_q + AW'(1);
            end
            if (in_valid && full)
                overflow_q <= 1'b1;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_requant_fifo.sv
// Self-checking bench for relu_requant_fifo.
// Expected activations are pushed to a scoreboard queue when a write is
// accepted. They are popped and compared when the read data appears.
module tb_relu_requant_fifo;

    localparam int SHIFT = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          global_rst;
    logic [31:0]   in_data;
    logic          in_valid, in_end, rd_en;
    logic [15:0]   out_data;
    logic          out_valid, full, empty, overflow, frame_done;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    relu_requant_fifo #(.SHIFT(SHIFT), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .global_rst(global_rst),
        .in_data(in_data), .in_valid(in_valid), .in_end(in_end), .rd_en(rd_en),
        .out_data(out_data), .out_valid(out_valid), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .frame_done(frame_done)
    );

    int n_chk = 0, n_fail = 0, fd_cnt = 0;

    // Bench-side model state
    logic [15:0] sb[$];
    int          mc;
    bit          movf, mpend, mprev;
    logic [15:0] mlast;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rq(input logic [31:0] d);
        longint unsigned lim;
        lim = 64'h8000 << SHIFT;
        if (d[31]) return 16'h0000;
        if (64'(d) >= lim) return 16'h7FFF;
        return 16'(d >> SHIFT);
    endfunction

    task automatic model_reset();
        sb.delete();
        mc = 0; movf = 0; mpend = 0; mprev = 0; mlast = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // One clock cycle. Drive the inputs, predict the effects of this edge,
    // then check the outputs #1 after the edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        bit wa, ra, fdn, rise;
        in_valid = v; in_data = d; rd_en = r;
        wa = v && (mc < DEPTH);
        ra = r && (mc > 0);
        if (v && !wa) movf = 1;
        if (wa) sb.push_back(rq(d));
        if (ra) mlast = sb.pop_front();
        fdn  = mpend && (mc == 0) && !wa;
        rise = in_end && !mprev;
        mpend = fdn ? 1'b0 : (mpend || rise);
        mprev = in_end;
        if (wa && !ra) mc++;
        else if (ra && !wa) mc--;
        @(posedge clk); #1;
        chk("out_valid", out_valid, ra);
        chk("out_data", out_data, mlast);
        chk("count", count, mc);
        chk("full", full, mc == DEPTH);
        chk("empty", empty, mc == 0);
        chk("overflow", overflow, movf);
        chk("frame_done", frame_done, fdn);
        if (frame_done) fd_cnt++;
    endtask

    logic [31:0] rq_tab [5] = '{32'h00012345, 32'hFFFF0000, 32'h007FFF00,
                                32'h007FFFFF, 32'h00800000};
    logic [15:0] rq_exp [5] = '{16'h0123, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF};

    initial begin
        global_rst = 1'b1; in_data = '0; in_valid = 0; in_end = 0; rd_en = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        global_rst = 1'b0;

        // Requant table: five writes, then five reads checked against the table
        for (int i = 0; i < 5; i++) cyc(1, rq_tab[i], 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1);
            chk("rq_tab", out_data, rq_exp[i]);
        end

        // Fill, then overflow on write 17
        for (int i = 1; i <= 17; i++) begin
            cyc(1, 32'(i) << SHIFT, 0);
            if (i == 16) begin
                chk("fill_full", full, 1);
                chk("fill_count16", count, 16);
            end
        end
        chk("ovf_set", overflow, 1);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 0, 1);
            chk("fill_order", out_data, i);
        end
        chk("drain_empty", empty, 1);
        chk("ovf_sticky", overflow, 1);

        // Empty edge cases: rd_en on empty, then write+read on empty
        cyc(0, 0, 1);
        chk("rd_empty_hold", out_data, 16);
        cyc(1, 32'h0000_4200, 1);
        chk("wr_rd_empty_cnt", count, 1);
        cyc(0, 0, 1);

        // Wrap and concurrency
        for (int i = 0; i < 10; i++) cyc(1, 32'(100 + i) << SHIFT, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 32'(200 + i) << SHIFT, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(1, ($urandom() & 32'h00FF_FFFF) | (i[0] ? 32'h8000_0000 : 32'h0), 1);
            chk("stream_count", count, 3);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);

        // Frame end: exactly one pulse after the drain, none while in_end is held
        fd_cnt = 0;
        for (int i = 0; i < 4; i++) cyc(1, 32'(i + 1) << SHIFT, 0);
        in_end = 1;
        cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        chk("fd_not_yet", frame_done, 0);
        cyc(0, 0, 0);
        chk("fd_pulse", frame_done, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        chk("fd_once", fd_cnt, 1);
        in_end = 0;
        cyc(0, 0, 0);

        // Async reset mid-stream with count=7 and end pending
        for (int i = 0; i < 7; i++) cyc(1, 32'(i + 50) << SHIFT, 0);
        in_end = 1;
        cyc(0, 0, 1);
        cyc(1, 32'h0001_0000, 0);
        chk("pre_rst_count", count, 7);
        in_valid = 1; rd_en = 1;
        #2 global_rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        in_end = 0; in_valid = 0; rd_en = 0;
        @(posedge clk); #1;
        chk_reset_vals("rst_hold");
        global_rst = 1'b0;
        model_reset();
        fd_cnt = 0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        chk("no_fd_after_rst", fd_cnt, 0);
        cyc(1, 32'h0000_0500, 0);
        cyc(0, 0, 1);
        chk("post_rst_data", out_data, 16'h0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/relu_requant_fifo.md
# relu_requant_fifo

Downstream stage of the convolution/pooling accelerator. Consumes the pooler's 32-bit signed result stream (data, valid, end) and applies ReLU, a fixed right shift and saturation to 16 bits. Results are buffered in a synchronous FIFO, and 16-bit activations are handed to the next layer on a read-request handshake. It also flags the end of a frame once every pooled result of that frame has been read out.

## Interface
- SHIFT, 8, arithmetic right-shift amount applied after ReLU (0..16)
- DEPTH, 16, FIFO entries; power of two, ≥2
- AW, 4, log2(DEPTH)
- clk  in  1  clock, all state on rising edge
- global_rst  in  1  asynchronous, active-high reset
- in_data  in  32  signed pooled result
- in_valid  in  1  in_data valid this cycle
- in_end  in  1  pooler end-of-frame level
- rd_en  in  1  read request from next layer
- out_data  out  16  requantized activation
- out_valid  out  1  out_data valid (one-cycle pulse per read)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  AW+1  occupied entries
- overflow  out  1  sticky: a write was dropped because the FIFO was full
- frame_done  out  1  one-cycle pulse: frame ended and FIFO drained

## Operation
- Requantize (combinational, before write):
  - if in_data[31]=1, the result is 0;
  - else v = in_data >> SHIFT (floor), and the result is min(v, 16'h7FFF).
- Write: when in_valid=1 and full=0, store the result at wr_ptr and increment wr_ptr mod DEPTH.
- Write with in_valid=1 and full=1: the result is dropped and overflow is set. overflow stays set until reset.
- Full is judged on the current count. A write while full is rejected even if rd_en is accepted in the same cycle.
- Read: when rd_en=1 and empty=0, out_data is loaded from rd_ptr, rd_ptr increments mod DEPTH, and out_valid is 1 on the next cycle.
- rd_en while empty is ignored: out_valid=0 next cycle and out_data holds its last value.
- Simultaneous accepted write and read leaves count unchanged. On an empty FIFO, only the write happens (no read-through).
- count updates by +1 (write only), −1 (read only) or 0. full and empty are decoded from registered count.
- End of frame:
  - A rising edge of in_end (registered in_end = 0, current = 1) sets end_pending.
  - When end_pending=1, count=0 and no write is accepted this cycle, frame_done pulses for one cycle next cycle and end_pending clears.
  - A second rising edge while end_pending=1 has no extra effect.
- Pointer wrap: both pointers wrap from DEPTH−1 to 0. Data order is strictly FIFO across the wrap.

## Timing
- Reset values: out_data=0, out_valid=0, full=0, empty=1, count=0, overflow=0, frame_done=0. Pointers and end_pending are 0.
- Reset is asynchronous and effective immediately. Mid-operation it discards all contents and pending end state. The first write is accepted on the first rising edge after release.
- Write latency: in_valid accepted at edge N gives count/empty updated after edge N, and the entry is readable by rd_en in cycle N+1.
- Read latency: rd_en sampled at edge M gives out_data/out_valid valid after edge M (one cycle). A back-to-back rd_en gives one word per cycle.
- Throughput: one write and one read per cycle sustained.
- frame_done: asserted on the edge after the cycle where end_pending=1 and count=0 (and no write); width exactly 1 cycle.
- Storage: a DEPTH×16 register array; no combinational path from in_* to out_*.

## Test plan
- Requant values (SHIFT=8), five writes then five reads:

  | in_data | out_data |
  |---|---|
  | 0x00012345 | 0x0123 |
  | 0xFFFF0000 | 0x0000 |
  | 0x007FFF00 | 0x7FFF |
  | 0x007FFFFF | 0x7FFF |
  | 0x00800000 | 0x7FFF |

  Read order matches write order, with out_valid one cycle after each rd_en.
- Fill/overflow: 17 consecutive writes with DEPTH=16 and no reads. full rises after write 16 and count=16. Write 17 is dropped and overflow=1 and stays set. The 16 reads return values 1..16 and then empty=1.
- Wrap and concurrency: write 10, read 10, then stream 40 words with rd_en and in_valid both held high. count stays constant and the output sequence equals the input sequence across multiple pointer wraps.
- Empty edge cases: rd_en on an empty FIFO gives out_valid=0. Write+read in the same cycle on an empty FIFO gives count=1 afterward and out_valid=0.
- Frame end: write 4 words, raise in_end, then read 4 words. frame_done pulses exactly once, one cycle after count reaches 0. Holding in_end high gives no further pulse.
- Async reset: assert global_rst mid-stream with count=7 and end_pending set. All outputs go to their reset values immediately without a clock edge, and no frame_done follows.
